dmr_fault_monitor: RTL

- Downstream consumer of the dual-ALU lockstep pair.
- Each cycle it takes both ALU result/carry pairs, forms a 9-bit syndrome and registers the mismatch decision.
- Keeps a saturating fault count and a sticky first-fault syndrome.
- Runs a state machine that raises a sticky alarm after THRESH consecutive mismatching samples.
- Replaces the simulation-only pass/fail print with synthesizable status for the management side.

---
 rtl/dmr_fault_monitor_if.sv | 30 +++
 rtl/dmr_fault_monitor.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/dmr_fault_monitor_if.sv
// Sample and status bundle between the lockstep ALU pair, the DMR fault
// monitor and the management side. The master drives the ALU sample and
// the clear. The slave (the monitor) returns the registered status.
interface dmr_fault_monitor_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [7:0]       alu_out1;
    logic [7:0]       alu_out2;
    logic             carry1;
    logic             carry2;
    logic             clr;
    logic             mismatch;
    logic [8:0]       syndrome;
    logic [8:0]       first_syn;
    logic             first_vld;
    logic [CNT_W-1:0] fault_cnt;
    logic [1:0]       state;
    logic             alarm;

    modport master (
        output in_valid, alu_out1, alu_out2, carry1, carry2, clr,
        input  mismatch, syndrome, first_syn, first_vld, fault_cnt, state, alarm
    );

    modport slave (
        input  in_valid, alu_out1, alu_out2, carry1, carry2, clr,
        output mismatch, syndrome, first_syn, first_vld, fault_cnt, state, alarm
    );
endinterface

// File: rtl/dmr_fault_monitor.sv
// DMR fault monitor: compares the two lockstep ALU outputs every valid cycle.
// It keeps a saturating fault count and a sticky first-fault syndrome.
// It escalates OK -> SUSPECT -> ALARM after THRESH consecutive mismatches.
// ALARM is sticky until clr or reset.
module dmr_fault_monitor #(
    parameter int CNT_W  = 8,
    parameter int THRESH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dmr_fault_monitor_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_ALARM   = 2'b10
    } state_e;

    localparam logic [3:0]       THRESH_C = 4'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             accept_s;
    logic [8:0]       syn_s;
    logic             miss_s;
    logic             match_s;

    state_e           state_q,     state_d;
    logic [3:0]       consec_q,    consec_d;
    logic             mismatch_q,  mismatch_d;
    logic [8:0]       syndrome_q,  syndrome_d;
    logic [8:0]       first_syn_q, first_syn_d;
    logic             first_vld_q, first_vld_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;
    logic             alarm_q,     alarm_d;

    // Classify the current sample; clr suppresses acceptance of the sample.
    always_comb begin
        accept_s = bus.in_valid & ~bus.clr;
        syn_s    = {bus.carry1 ^ bus.carry2, bus.alu_out1 ^ bus.alu_out2};
        miss_s   = accept_s & (syn_s != 9'h000);
        match_s  = accept_s & (syn_s == 9'h000);
    end

    // Datapath next state: syndrome, pulse, saturating counters, sticky capture.
    always_comb begin
        syndrome_d  = syndrome_q;
        mismatch_d  = miss_s;
        fault_cnt_d = fault_cnt_q;
        first_syn_d = first_syn_q;
        first_vld_d = first_vld_q;
        consec_d    = consec_q;
        if (bus.clr) begin
            fault_cnt_d = {CNT_W{1'b0}};
            first_syn_d = 9'h000;
            first_vld_d = 1'b0;
            consec_d    = 4'd0;
        end else if (miss_s) begin
            syndrome_d = syn_s;
            if (fault_cnt_q != CNT_MAX) begin
                fault_cnt_d = fault_cnt_q + CNT_W'(1);
            end else begin
                fault_cnt_d = fault_cnt_q;
            end
            if (!first_vld_q) begin
                first_syn_d = syn_s;
                first_vld_d = 1'b1;
            end else begin
                first_syn_d = first_syn_q;
                first_vld_d = first_vld_q;
            end
            if (consec_q < THRESH_C) begin
                consec_d = consec_q + 4'd1;
            end else begin
                consec_d = consec_q;
            end
        end else if (match_s) begin
            syndrome_d = syn_s;
            consec_d   = 4'd0;
        end else begin
            syndrome_d = syndrome_q;
        end
    end

    // Escalation FSM next state; ALARM is left only by clr, code 11 falls to OK.
    always_comb begin
        state_d = state_q;
        if (bus.clr) begin
            state_d = ST_OK;
        end else begin
            case (state_q)
                ST_OK: begin
                    if (miss_s) begin
                        state_d = (THRESH_C == 4'd1) ? ST_ALARM : ST_SUSPECT;
                    end else begin
                        state_d = ST_OK;
                    end
                end
                ST_SUSPECT: begin
                    if (match_s) begin
                        state_d = ST_OK;
                    end else if (miss_s && (consec_d == THRESH_C)) begin
                        state_d = ST_ALARM;
                    end else begin
                        state_d = ST_SUSPECT;
                    end
                end
                ST_ALARM: state_d = ST_ALARM;
                default:  state_d = ST_OK;
            endcase
        end
        alarm_d = (state_d == ST_ALARM);
    end

    // State and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_OK;
            consec_q    <= 4'd0;
            mismatch_q  <= 1'b0;
            syndrome_q  <= 9'h000;
            first_syn_q <= 9'h000;
            first_vld_q <= 1'b0;
            fault_cnt_q <= {CNT_W{1'b0}};
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            consec_q    <= consec_d;
            mismatch_q  <= mismatch_d;
            syndrome_q  <= syndrome_d;
            first_syn_q <= first_syn_d;
            first_vld_q <= first_vld_d;
            fault_cnt_q <= fault_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    assign bus.mismatch  = mismatch_q;
    assign bus.syndrome  = syndrome_q;
    assign bus.first_syn = first_syn_q;
    assign bus.first_vld = first_vld_q;
    assign bus.fault_cnt = fault_cnt_q;
    assign bus.state     = state_q;
    assign bus.alarm     = alarm_q;
endmodule
